display_reg_bcd: RTL and testbench

Memory-mapped output register between the Hack CPU data bus and the Screen seven-segment stage.
- Captures 16-bit CPU writes and drives the Screen block's 16-bit `din`.
- Hex mode: the value is passed through unchanged.
- Decimal mode: a sequential double-dabble converter renders the value as 4 packed BCD digits, or as an overflow pattern.
- A control register selects the mode; the CPU can read back both registers.

---
 rtl/display_reg_bcd_pkg.sv | 16 +
 rtl/display_reg_bcd_if.sv | 11 +
 rtl/display_reg_bcd_bin16_to_bcd.sv | 72 +++++++
 rtl/display_reg_bcd.sv | 75 +++++++
 tb/tb_display_reg_bcd.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/display_reg_bcd_pkg.sv
// Shared constants and types for the display register and its BCD converter.
package display_reg_bcd_pkg;
  localparam int ADDR_W       = 15;
  localparam int DATA_W       = 16;
  localparam int CTRL_OFFSET  = 1;
  localparam int BCD_DIGITS   = 5;
  localparam int SHIFT_CYCLES = 16;
  localparam int CNT_W        = $clog2(SHIFT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/display_reg_bcd_if.sv
// CPU-side memory-mapped bus: address, write data/strobe and combinational readback.
interface display_reg_bcd_if;
  import display_reg_bcd_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/display_reg_bcd_bin16_to_bcd.sv
// Sequential double-dabble: LOAD, 16 add-3/shift steps, then a one-cycle DONE pulse.
module bin16_to_bcd
  import display_reg_bcd_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic [DATA_W-1:0]       din_i,
  output logic                    done_o,
  output logic                    busy_o,
  output logic [4*BCD_DIGITS-1:0] bcd_o
);
  localparam int SR_W = 4*BCD_DIGITS + DATA_W;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOAD  = LOAD;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]      state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Correct every BCD nibble that would overflow past 9 after the next doubling.
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[DATA_W+4*i +: 4] >= 4'd5)
        adj[DATA_W+4*i +: 4] = adj[DATA_W+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: begin
        sr_d    = {{(4*BCD_DIGITS){1'b0}}, din_i};
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sr_d  = {adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(SHIFT_CYCLES-1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A fresh start supersedes whatever is in flight, including a pending DONE.
    if (start_i)      state_d = S_LOAD;
    else if (abort_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign done_o = (state_q == S_DONE);
  assign busy_o = (state_q != S_IDLE);
  assign bcd_o  = sr_q[SR_W-1:DATA_W];
endmodule

// File: rtl/display_reg_bcd.sv
// Memory-mapped display register: value/control registers, readback, and hex or BCD rendering.
module display_reg_bcd
  import display_reg_bcd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 15'h4000,
  parameter logic [DATA_W-1:0] OVF_PATTERN = 16'hEEEE
) (
  input  logic              clk,
  input  logic              reset,
  display_reg_bcd_if.slave  bus,
  output logic [DATA_W-1:0] dout,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = BASE_ADDR + ADDR_W'(CTRL_OFFSET);

  logic [DATA_W-1:0]       value_q, value_d;
  logic                    mode_q, mode_d;
  logic [DATA_W-1:0]       dout_q, dout_d;
  logic                    val_we, ctl_we, cvt_start, cvt_abort, cvt_done;
  logic [4*BCD_DIGITS-1:0] cvt_bcd;

  assign val_we = bus.we && (bus.addr == BASE_ADDR);
  assign ctl_we = bus.we && (bus.addr == CTRL_ADDR);

  // Converter samples value_q in LOAD, one edge after the write lands.
  assign cvt_start = (val_we && mode_q) || (ctl_we && bus.wdata[0]);
  assign cvt_abort = ctl_we && !bus.wdata[0];

  bin16_to_bcd u_cvt (
    .clk     (clk),
    .reset   (reset),
    .start_i (cvt_start),
    .abort_i (cvt_abort),
    .din_i   (value_q),
    .done_o  (cvt_done),
    .busy_o  (busy),
    .bcd_o   (cvt_bcd)
  );

  // Writes take priority over a completing conversion so stale results never land.
  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    if (val_we) begin
      value_d = bus.wdata;
      if (!mode_q) dout_d = bus.wdata;
    end else if (ctl_we) begin
      mode_d = bus.wdata[0];
      if (!bus.wdata[0]) dout_d = value_q;
    end else if (cvt_done) begin
      dout_d = (cvt_bcd[4*BCD_DIGITS-1 -: 4] != 4'd0) ? OVF_PATTERN : cvt_bcd[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.addr == BASE_ADDR)      bus.rdata = value_q;
    else if (bus.addr == CTRL_ADDR) bus.rdata = {{(DATA_W-1){1'b0}}, mode_q};
  end

  assign dout = dout_q;
endmodule

// File: tb/tb_display_reg_bcd.sv
// Directed bench with a cycle-stamped scoreboard of expected dout updates.
module tb_display_reg_bcd;
  localparam logic [14:0] BASE = 15'h4000;
  localparam logic [14:0] CTRL = 15'h4001;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dout;
  logic        busy;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct { int cyc; logic [15:0] val; } exp_t;
  exp_t        sb[$];
  logic [15:0] prev_dout = 16'h0;
  bit          mon_en = 1'b0;
  logic [15:0] m_val = 16'h0;
  bit          m_mode = 1'b0;

  display_reg_bcd_if bus ();

  display_reg_bcd #(.BASE_ADDR(15'h4000), .OVF_PATTERN(16'hEEEE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .dout  (dout),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] dec(input int v);
    if (v > 9999) return 16'hEEEE;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Any new write supersedes a conversion result not yet due.
  task automatic sb_cancel();
    while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
  endtask

  // Every dout change must be one the model predicted, at the predicted cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("dout_update", dout, e.val);
      end else begin
        chk("dout_hold", dout, prev_dout);
      end
      prev_dout = dout;
    end
  end

  task automatic wr_val(input logic [15:0] d);
    @(negedge clk);
    bus.addr = BASE; bus.wdata = d; bus.we = 1'b1;
    sb_cancel();
    m_val = d;
    if (m_mode) sb.push_back('{cyc + 19, dec(int'(d))});
    else        sb.push_back('{cyc + 1, d});
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic wr_ctl(input logic [15:0] d);
    @(negedge clk);
    bus.addr = CTRL; bus.wdata = d; bus.we = 1'b1;
    sb_cancel();
    m_mode = d[0];
    if (m_mode) sb.push_back('{cyc + 19, dec(int'(m_val))});
    else        sb.push_back('{cyc + 1, m_val});
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] exp);
    @(negedge clk);
    bus.addr = a; bus.we = 1'b0;
    #1 chk(tag, bus.rdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.addr = 15'h0; bus.wdata = 16'h0; bus.we = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_dout", dout, 16'h0);
    chk("rst_busy", {15'h0, busy}, 16'h0);
    rd("rst_val", BASE, 16'h0);
    rd("rst_mode", CTRL, 16'h0);
    prev_dout = dout;
    mon_en = 1'b1;

    // Hex pass-through
    wr_val(16'h1234);
    chk("hex_busy", {15'h0, busy}, 16'h0);
    rd("hex_rdata", BASE, 16'h1234);
    repeat (2) @(negedge clk);

    // Decimal: busy exactly 18 cycles, dout held, then BCD
    wr_ctl(16'h0001);
    repeat (20) @(negedge clk);
    rd("dec_mode_rd", CTRL, 16'h0001);
    wr_val(16'h04D2);
    for (int i = 0; i < 18; i++) begin
      chk("dec_busy_hi", {15'h0, busy}, 16'h1);
      @(negedge clk);
    end
    chk("dec_busy_lo", {15'h0, busy}, 16'h0);
    repeat (2) @(negedge clk);

    // Decimal boundaries
    wr_val(16'd9999);  repeat (20) @(negedge clk);
    wr_val(16'd10000); repeat (20) @(negedge clk);
    wr_val(16'hFFFF);  repeat (20) @(negedge clk);
    wr_val(16'h0000);  repeat (20) @(negedge clk);
    wr_val(16'h8000);  repeat (20) @(negedge clk);
    wr_val(16'd5);     repeat (20) @(negedge clk);

    // Restart mid-conversion: only the later value appears
    wr_val(16'h04D2);
    repeat (4) @(negedge clk);
    wr_val(16'h0007);
    repeat (20) @(negedge clk);

    // Reset in the middle of a conversion
    wr_val(16'h04D2);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    sb_cancel();
    sb.push_back('{cyc + 1, 16'h0000});
    m_val = 16'h0; m_mode = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", {15'h0, busy}, 16'h0);
    rd("mid_rst_mode", CTRL, 16'h0);
    rd("mid_rst_val", BASE, 16'h0);
    wr_val(16'hBEEF);
    repeat (2) @(negedge clk);

    // Unmapped address, then decimal->hex re-render
    @(negedge clk);
    bus.addr = BASE + 15'd2; bus.wdata = 16'h5555; bus.we = 1'b1;
    @(negedge clk);
    bus.we = 1'b0;
    rd("unmapped_rd", BASE + 15'd2, 16'h0);
    rd("unmapped_val", BASE, 16'hBEEF);
    rd("unmapped_mode", CTRL, 16'h0);
    wr_ctl(16'hFFFF);
    repeat (3) @(negedge clk);
    wr_val(16'h04D2);
    repeat (20) @(negedge clk);
    wr_ctl(16'h0000);
    repeat (2) @(negedge clk);
    wr_ctl(16'h0001);
    repeat (5) @(negedge clk);
    wr_ctl(16'h0000);
    repeat (25) @(negedge clk);

    chk("sb_drained", 16'(sb.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
